// File: rtl/arbitro_mux_if.sv
// Bundle of the arbiter's request/data inputs and grant/mux outputs.
interface arbitro_mux_if;
  logic [3:0] req;
  logic [3:0] D;
  logic [3:0] gnt;
  logic [1:0] S;
  logic       busy;
  logic       Y;

  modport master (output req, D, input gnt, S, busy, Y);
  modport slave  (input req, D, output gnt, S, busy, Y);
endinterface

// File: rtl/arbitro_mux.sv
// 4-way round-robin arbiter driving a registered 4:1 data mux.
// Optional hold timeout enabled by defining ARB_TIMEOUT_EN.
module arbitro_mux #(
  parameter int unsigned MAX_HOLD = 8
) (
  input logic          clk,
  input logic          rst,
  arbitro_mux_if.slave bus
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_hold
    $error("MAX_HOLD out of range 2..255");
  end

  logic [0:0] r_state;
  logic [1:0] r_last;
  logic [3:0] r_gnt;
  logic [1:0] r_s;
  logic       r_busy;
  logic       r_y;

  logic [1:0] w_win;
  logic [1:0] w_idx;
  logic       w_any;
  logic       w_expire;
  logic       w_new;

  // Scan downward so the nearest requester after r_last is written last.
  always_comb begin
    w_win = r_last;
    w_idx = r_last;
    for (int unsigned k = 4; k > 0; k--) begin
      w_idx = r_last + 2'(k);
      if (bus.req[w_idx]) w_win = w_idx;
    end
  end

  assign w_any = |bus.req;

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
  logic [7:0] r_cnt;

  assign w_expire = (r_cnt == HOLD_LAST) && |(bus.req & ~r_gnt);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_new) begin
      r_cnt <= '0;
    end else if (r_state == GRANT && r_cnt != HOLD_LAST) begin
      r_cnt <= r_cnt + 8'd1;
    end
  end
`else
  assign w_expire = 1'b0;
`endif

  assign w_new = w_any && ((r_state == IDLE) || !bus.req[r_s] || w_expire);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_last  <= 2'd3;
      r_gnt   <= '0;
      r_s     <= '0;
      r_busy  <= 1'b0;
      r_y     <= 1'b0;
    end else begin
      r_y <= r_busy & bus.D[r_s];
      if (w_new) begin
        r_state <= GRANT;
        r_gnt   <= 4'b0001 << w_win;
        r_s     <= w_win;
        r_last  <= w_win;
        r_busy  <= 1'b1;
      end else if (r_state == GRANT && !w_any) begin
        r_state <= IDLE;
        r_gnt   <= '0;
        r_busy  <= 1'b0;
      end
    end
  end

  assign bus.gnt  = r_gnt;
  assign bus.S    = r_s;
  assign bus.busy = r_busy;
  assign bus.Y    = r_y;

endmodule
